// File: rtl/apb_i2c_completer.sv
// APB completer for the I2C controller register file: CTRL, SADDR, STATUS,
// and the TX/RX byte FIFOs that connect to the I2C byte engine.
// Every access takes one SETUP-state cycle, then WAIT_STATES ACCESS cycles
// with pready=0, then one completing ACCESS cycle with pready=1. Side effects
// commit only on that completing cycle.
module apb_i2c_completer #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              ctrl_en,
    output logic [6:0]        saddr,
    output logic              irq
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam int              CW       = AW + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [3:0]      WS_CNT   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        wait_q, wait_d;

    logic              en_q, en_d;
    logic              irq_en_q, irq_en_d;
    logic [6:0]        saddr_q, saddr_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] tx_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0]     tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [AW-1:0]     rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

    logic [2:0]        offset;
    logic [4:0]        status;
    logic              tx_empty, tx_full, rx_empty, rx_full;
    logic              tx_pop, tx_push, rx_pop, rx_push;
    logic              ctrl_we, saddr_we, ovf_clr, ovf_set;
    logic              unused_paddr;

    // Only the low three address bits take part in the decode.
    assign offset       = paddr[2:0];
    assign unused_paddr = ^paddr[ADDR_W-1:3];

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);
    assign status   = {ovf_q, rx_full, rx_empty, tx_full, tx_empty};

    // The engine side runs independently of the APB handshake. A push into a
    // full FIFO still lands when a pop frees a slot in the same cycle.
    assign tx_pop  = !tx_empty && tx_ready;
    assign rx_push = rx_valid && (!rx_full || rx_pop);
    assign ovf_set = rx_valid && rx_full && !rx_pop;

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_empty ? '0 : tx_mem_q[tx_rd_q];
    assign ctrl_en  = en_q;
    assign saddr    = saddr_q;
    assign irq      = irq_en_q && (!rx_empty || ovf_q);

    // Handshake FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Handshake FSM next-state logic and wait counter.
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (psel && !penable) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                wait_d  = '0;
            end
            ST_ACCESS: begin
                if (!psel) begin
                    state_d = ST_IDLE;
                end else if (wait_q == WS_CNT) begin
                    state_d = (psel && !penable) ? ST_SETUP : ST_IDLE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs and register-map decode of the completing cycle.
    always_comb begin
        pready   = (state_q == ST_ACCESS) && psel && (wait_q == WS_CNT);
        prdata   = '0;
        pslverr  = 1'b0;
        ctrl_we  = 1'b0;
        saddr_we = 1'b0;
        ovf_clr  = 1'b0;
        tx_push  = 1'b0;
        rx_pop   = 1'b0;
        if (pready) begin
            case (offset)
                3'd0: begin
                    if (pwrite) ctrl_we = 1'b1;
                    else        prdata  = DATA_W'({irq_en_q, en_q});
                end
                3'd1: begin
                    if (pwrite) saddr_we = 1'b1;
                    else        prdata   = DATA_W'(saddr_q);
                end
                3'd2: begin
                    if (pwrite) ovf_clr = pwdata[4];
                    else        prdata  = DATA_W'(status);
                end
                3'd3: begin
                    if (!pwrite || (tx_full && !tx_pop)) pslverr = 1'b1;
                    else                                 tx_push = 1'b1;
                end
                3'd4: begin
                    if (!pwrite && !rx_empty) begin
                        rx_pop = 1'b1;
                        prdata = rx_mem_q[rx_rd_q];
                    end else begin
                        pslverr = 1'b1;
                    end
                end
                default: pslverr = 1'b1;
            endcase
        end
    end

    // Next-state values for the control registers and FIFO pointers.
    always_comb begin
        en_d     = en_q;
        irq_en_d = irq_en_q;
        saddr_d  = saddr_q;
        if (ctrl_we) begin
            en_d     = pwdata[0];
            irq_en_d = pwdata[1];
        end
        if (saddr_we) saddr_d = pwdata[6:0];
        // A fresh overflow beats a same-cycle clear.
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;
        tx_wr_d  = tx_push ? tx_wr_q + AW'(1) : tx_wr_q;
        tx_rd_d  = tx_pop  ? tx_rd_q + AW'(1) : tx_rd_q;
        rx_wr_d  = rx_push ? rx_wr_q + AW'(1) : rx_wr_q;
        rx_rd_d  = rx_pop  ? rx_rd_q + AW'(1) : rx_rd_q;
        tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    end

    // Control registers, sticky overflow flag and FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            saddr_q  <= '0;
            ovf_q    <= 1'b0;
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            saddr_q  <= saddr_d;
            ovf_q    <= ovf_d;
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

    // FIFO storage writes.
    // NOTE: storage has no reset; empty counts and the zeroed tx_data view hide stale entries.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= pwdata;
        if (rx_push) rx_mem_q[rx_wr_q] <= rx_data;
    end

endmodule
